// File: rtl/seg_cascade_counter_if.sv
// Counter control/status bundle for seg_cascade_counter.
// master drives en/up/load/load_val/mod_val/sat and reads q/at_term/wrap_p/seg_cy.
interface seg_cascade_counter_if #(
   parameter int SEG_W = 2,
   parameter int SEGS  = 4
) ();
   localparam int W = SEG_W * SEGS;

   logic            en;
   logic            up;
   logic            load;
   logic [W-1:0]    load_val;
   logic [W-1:0]    mod_val;
   logic            sat;
   logic [W-1:0]    q;
   logic            at_term;
   logic            wrap_p;
   logic [SEGS-2:0] seg_cy;

   modport master (
      output en, up, load, load_val, mod_val, sat,
      input  q, at_term, wrap_p, seg_cy
   );

   modport slave (
      input  en, up, load, load_val, mod_val, sat,
      output q, at_term, wrap_p, seg_cy
   );
endinterface

// File: rtl/seg_cascade_counter.sv
// Up/down counter of SEGS cascaded SEG_W-bit segments with modulo, load, sat/wrap.
// Ports: clk, rst (sync, active-high), bus (slave modport: controls in, q/flags out).
module seg_cascade_counter #(
   parameter int SEG_W = 2,
   parameter int SEGS  = 4
) (
   input logic                  clk,
   input logic                  rst,
   seg_cascade_counter_if.slave bus
);
   localparam int W = SEG_W * SEGS;

   logic [W-1:0]     r_q;
   logic             r_wrap_p;

   logic [W-1:0]     w_q_nxt;
   logic             w_wrap_nxt;
   logic             w_step;
   logic [W-1:0]     w_cas;
   logic [SEGS-1:0]  w_seg_en;
   logic [SEG_W-1:0] w_seg;
   logic             w_acc;

   // Ripple-enable chain: segment i steps only if all lower
   // segments sit at their carry (all-ones) / borrow (all-zeros) value.
   always_comb begin
      w_cas    = r_q;
      w_seg_en = '0;
      w_seg    = '0;
      w_acc    = w_step;
      for (int i = 0; i < SEGS; i++) begin
         w_seg       = r_q[i*SEG_W +: SEG_W];
         w_seg_en[i] = w_acc;
         if (w_acc) begin
            w_cas[i*SEG_W +: SEG_W] = bus.up ? w_seg + 1'b1
                                             : w_seg - 1'b1;
         end
         w_acc = w_acc & (bus.up ? (&w_seg) : ~(|w_seg));
      end
   end

   // w_step marks a plain +/-1 step; terminal cases bypass the chain.
   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      w_step     = 1'b0;
      if (bus.load) begin
         w_q_nxt = (bus.load_val < bus.mod_val) ? bus.load_val
                                                : bus.mod_val;
      end else if (bus.en) begin
         if (bus.up) begin
            if (r_q >= bus.mod_val) begin
               if (!bus.sat) begin
                  w_q_nxt    = '0;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_step = 1'b1;
            end
         end else begin
            if (r_q > bus.mod_val) begin
               w_q_nxt = bus.mod_val;
            end else if (r_q == '0) begin
               if (!bus.sat) begin
                  w_q_nxt    = bus.mod_val;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_step = 1'b1;
            end
         end
         if (w_step) begin
            w_q_nxt = w_cas;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q      <= '0;
         r_wrap_p <= 1'b0;
      end else begin
         r_q      <= w_q_nxt;
         r_wrap_p <= w_wrap_nxt;
      end
   end

   assign bus.q       = r_q;
   assign bus.wrap_p  = r_wrap_p;
   assign bus.at_term = bus.up ? (r_q == bus.mod_val) : (r_q == '0);
   assign bus.seg_cy  = w_seg_en[SEGS-1:1];
endmodule

// File: tb/tb_seg_cascade_counter.sv
// Self-checking bench for seg_cascade_counter (SEG_W=2, SEGS=4).
// Scoreboard queue of expected q/wrap_p; combinational flags checked pre-edge.
module tb_seg_cascade_counter;
   localparam int SEG_W = 2;
   localparam int SEGS  = 4;
   localparam int W     = SEG_W * SEGS;

   typedef struct {
      int q;
      int w;
   } exp_t;

   logic clk;
   logic rst;

   seg_cascade_counter_if #(.SEG_W(SEG_W), .SEGS(SEGS)) bus ();

   seg_cascade_counter #(.SEG_W(SEG_W), .SEGS(SEGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec;
   int    n_bad;
   int    m_q;
   bit    m_ok;
   string phase;
   exp_t  sb[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0d, want %0d", phase, tag, got, exp);
      end
   endtask

   task automatic cyc(input bit r_i, input bit en_i, input bit up_i,
                      input bit ld_i, input int lv, input int mv,
                      input bit sat_i);
      exp_t e;
      bit   stp;
      int   mask;
      logic [SEGS-2:0] cy;
      @(negedge clk);
      rst          = r_i;
      bus.en       = en_i;
      bus.up       = up_i;
      bus.load     = ld_i;
      bus.load_val = lv[W-1:0];
      bus.mod_val  = mv[W-1:0];
      bus.sat      = sat_i;
      #1;
      stp = 1'b0;
      e.q = m_q;
      e.w = 0;
      if (ld_i) begin
         e.q = (lv < mv) ? lv : mv;
      end else if (en_i) begin
         if (up_i) begin
            if (m_q >= mv) begin
               if (!sat_i) begin
                  e.q = 0;
                  e.w = 1;
               end
            end else begin
               e.q = m_q + 1;
               stp = 1'b1;
            end
         end else begin
            if (m_q > mv) begin
               e.q = mv;
            end else if (m_q == 0) begin
               if (!sat_i) begin
                  e.q = mv;
                  e.w = 1;
               end
            end else begin
               e.q = m_q - 1;
               stp = 1'b1;
            end
         end
      end
      if (m_ok) begin
         chk("at_term", bus.at_term,
             up_i ? (m_q == mv) : (m_q == 0));
         for (int i = 0; i < SEGS - 1; i++) begin
            mask  = (1 << ((i + 1) * SEG_W)) - 1;
            cy[i] = stp && (up_i ? ((m_q & mask) == mask)
                                 : ((m_q & mask) == 0));
         end
         chk("seg_cy", bus.seg_cy, cy);
      end
      if (r_i) begin
         e.q = 0;
         e.w = 0;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("q", bus.q, e.q);
      chk("wrap_p", bus.wrap_p, e.w);
      m_q  = e.q;
      m_ok = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      m_q   = 0;
      m_ok  = 1'b0;
      rst   = 1'b1;
      bus.en = 1'b0;
      bus.up = 1'b1;
      bus.load = 1'b0;
      bus.load_val = '0;
      bus.mod_val = '0;
      bus.sat = 1'b0;

      phase = "reset";
      cyc(1, 0, 1, 0, 0, 255, 0);
      cyc(1, 0, 1, 0, 0, 255, 0);
      chk("rst_q", bus.q, 0);

      phase = "t1_full";
      for (int i = 0; i < 260; i++) cyc(0, 1, 1, 0, 0, 255, 0);
      chk("end_q", bus.q, 4);

      phase = "t2_mod9";
      cyc(0, 0, 1, 1, 0, 9, 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 9, 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 9, 1);
      chk("sat_q", bus.q, 9);
      chk("sat_wrap", bus.wrap_p, 0);

      phase = "t3_down";
      cyc(0, 1, 0, 1, 2, 9, 0);
      chk("load_q", bus.q, 2);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 9, 0);
      chk("after_wrap_q", bus.q, 8);
      cyc(0, 0, 0, 1, 0, 9, 1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 9, 1);
      chk("sat0_q", bus.q, 0);

      phase = "t4_clamp";
      cyc(0, 1, 1, 1, 200, 50, 0);
      chk("clamp_q", bus.q, 50);
      cyc(0, 1, 0, 0, 0, 20, 0);
      chk("down_clamp_q", bus.q, 20);
      cyc(0, 1, 1, 0, 0, 20, 0);
      chk("over_wrap_q", bus.q, 0);
      chk("over_wrap_p", bus.wrap_p, 1);

      phase = "t5_rst";
      cyc(0, 0, 1, 1, 37, 255, 0);
      cyc(1, 1, 1, 1, 99, 255, 0);
      chk("rst_mid_q", bus.q, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 255, 0);

      phase = "t6_alt";
      cyc(0, 0, 1, 1, 4, 255, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2) == 0, 0, 0, 255, 0);
      cyc(0, 0, 1, 1, 3, 255, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2) == 0, 0, 0, 255, 0);

      phase = "mod0";
      for (int i = 0; i < 4; i++) cyc(0, 1, i < 2, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 1);

      phase = "rand";
      for (int i = 0; i < 400; i++) begin
         int sel;
         int mv;
         sel = $urandom_range(0, 9);
         mv  = (sel < 5) ? $urandom_range(0, 20)
             : (sel < 8) ? 255 : $urandom_range(0, 255);
         cyc($urandom_range(0, 49) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1),
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 255),
             mv,
             $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/seg_cascade_counter.md
Name: seg_cascade_counter

Overview:
- Parametrised up/down counter built as a cascade of SEGS identical SEG_W-bit segments with a ripple-enable carry/borrow chain.
- Adds the following to the fixed-width cascaded counters already in the codebase: enable, direction, synchronous load, programmable modulo, wrap/saturate mode, and status flags.
- Used as the general event, timer and address counter in datapath and testbench infrastructure.

Parameters:
SEG_W, 2, width of one segment in bits (>=1)
SEGS, 4, number of cascaded segments (>=2); total width W = SEG_W*SEGS

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable; one step per cycle when high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load request
load_val  input  W  value to load
mod_val  input  W  terminal count; legal range of q is 0..mod_val
sat  input  1  mode: 1 = saturate at end of range, 0 = wrap
q  output  W  registered count value
at_term  output  1  combinational: q==mod_val when up=1, q==0 when up=0
wrap_p  output  1  registered one-cycle pulse on the cycle after a wrap occurred
seg_cy  output  SEGS-1  combinational: seg_cy[i]=1 when en=1, no load, the step is not a terminal-case step, and segment i passes a carry (up) or borrow (down) into segment i+1 this cycle

Behaviour:
- Reset: clk and rst are as stated in Ports. When rst is sampled high:
  - q <= 0
  - wrap_p <= 0
- Priority each edge: rst > load > en. With en=0 and load=0, q holds and wrap_p <= 0.
- Load:
  - q <= min(load_val, mod_val).
  - wrap_p <= 0.
  - Load ignores en, up and sat.
- Segment structure:
  - Segment 0 steps whenever a step occurs.
  - Segment i>0 steps only when every lower segment is all-ones (up) or all-zeros (down).
  - Each segment wraps modulo 2^SEG_W internally.
  - The result must equal plain W-bit q±1 for every non-terminal step.
- Up step (en=1, up=1):
  - q < mod_val: q <= q+1, wrap_p <= 0.
  - q == mod_val, sat=0: q <= 0, wrap_p <= 1.
  - q == mod_val, sat=1: q holds, wrap_p <= 0.
  - q > mod_val (mod_val lowered mid-count): treated as q==mod_val case.
- Down step (en=1, up=0):
  - 0 < q <= mod_val: q <= q-1, wrap_p <= 0.
  - q == 0, sat=0: q <= mod_val, wrap_p <= 1.
  - q == 0, sat=1: q holds, wrap_p <= 0.
  - q > mod_val: q <= mod_val, wrap_p <= 0 (clamp, not a wrap).
- Terminal-case steps do not drive seg_cy; seg_cy is 0 on those cycles.
- mod_val == 0: q is held at 0 by every step. wrap_p pulses each enabled cycle when sat=0.
- mod_val == 2^W-1: full natural binary range; the up wrap 2^W-1 -> 0 is reported via wrap_p.
- Direction may change on any cycle. There is no pipeline: the new q is visible one cycle after the enabling edge (latency 1).
- rst asserted mid-count or coincident with load/en: rst wins and all outputs return to reset values.
- All inputs are sampled only at the rising edge. Combinational outputs reflect current q, up and mod_val.

Test Plan:
(Defaults SEG_W=2, SEGS=4, W=8.)
1. rst=1 for 2 cycles, then en=1, up=1, mod_val=255, sat=0, 260 cycles:
   - q runs 0..255, then 0.
   - wrap_p high exactly one cycle after q=255.
   - seg_cy[0] high at q=3,7,...; seg_cy[2] high at q=63,127,191 only.
2. mod_val=9, up=1, sat=0, from q=0, 12 cycles:
   - q 0..9, 0, 1.
   - at_term high when q=9.
   - Then sat=1: q sticks at 9 with wrap_p=0.
3. up=0, mod_val=9, sat=0, load_val=2 with load=1:
   - q=2, then 1, 0, 9, 8.
   - wrap_p pulses once after 0->9.
   - sat=1 from q=0 holds 0.
4. load=1, en=1, load_val=200, mod_val=50: q=50 (clamped), wrap_p=0.
   - Then mod_val=20 with up=0: q->20.
   - Then up=1: q->0 with wrap_p=1.
5. rst=1 asserted together with load=1 and en=1 while q=37:
   - q=0 and wrap_p=0 next cycle.
   - en=0 for 5 cycles: q holds 0.
6. Alternate up every cycle from q=4, mod_val=255:
   - q 5, 4, 5, 4.
   - seg_cy[0] high only on the 3<->4 boundary steps, never on others.
